td4_clock_gen: RTL and testbench

- Upstream stage of the TD4 CPU top. Derives the CPU single-cycle clock-enable from the fast board clock.
- Supports the classic TD4 clock-select modes: 1 Hz, 10 Hz, manual single-step from a push button, and halt.
- The CPU advances its state only in cycles where cpu_ce=1. It also exports a running count of issued enables for debug and LEDs.

---
 rtl/td4_clock_gen.sv | 126 ++++++++++++
 tb/tb_td4_clock_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/td4_clock_gen.sv
// td4_clock_gen
//   Derives the single-cycle clock enable for the TD4 CPU from the fast board
//   clock. Supports 1 Hz, 10 Hz, manual single-step from a push button, and
//   halt. Also keeps an 8-bit wrapping count of issued enables for debug LEDs.
//
// Ports
//   clock     in   board clock, all logic on the rising edge
//   reset     in   asynchronous active-high reset
//   mode      in   [1:0] raw select switches: 00=1 Hz, 01=10 Hz, 10=manual, 11=halt
//   step_btn  in   raw bouncing push button, active-high
//   cpu_ce    out  one-clock-wide enable pulse to the CPU
//   ce_count  out  [7:0] number of cpu_ce pulses issued, modulo 256
//
// States (mode_q)
//   state  | meaning
//   HZ1    | prescaler divides by CLK_FREQ
//   HZ10   | prescaler divides by CLK_FREQ/10
//   MANUAL | one enable per debounced button press
//   HALT   | no enables; entered after reset

module td4_clock_gen #(
    parameter int CLK_FREQ        = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       step_btn,
    output logic       cpu_ce,
    output logic [7:0] ce_count
);

    localparam int PW = $clog2(CLK_FREQ);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [PW-1:0] DIV1_M1  = PW'(CLK_FREQ - 1);
    localparam logic [PW-1:0] DIV10_M1 = PW'(CLK_FREQ / 10 - 1);
    localparam logic [DW-1:0] DB_M1    = DW'(DEBOUNCE_CYCLES - 1);

    // Encoding matches the switch values so the synchronised input maps directly.
    typedef enum logic [1:0] {
        HZ1    = 2'b00,
        HZ10   = 2'b01,
        MANUAL = 2'b10,
        HALT   = 2'b11
    } state_t;

    logic [1:0]    mode_s1;
    logic [1:0]    mode_s;
    state_t        mode_q;
    logic          btn_s1;
    logic          btn_s;
    logic          btn_db;
    logic          btn_db_d;
    logic [DW-1:0] db_cnt;
    logic [PW-1:0] prescaler;

    logic [PW-1:0] div_m1;
    logic          mode_chg;
    logic          ce_next;

    always_comb begin
        div_m1   = (mode_q == HZ10) ? DIV10_M1 : DIV1_M1;
        mode_chg = (state_t'(mode_s) != mode_q);
        ce_next  = 1'b0;
        // A mode change suppresses the enable for that cycle, whatever the old mode.
        if (!mode_chg) begin
            case (mode_q)
                HZ1, HZ10: ce_next = (prescaler == div_m1);
                // btn_db_d lags btn_db by one cycle, so this is a debounced rising edge.
                // Entering MANUAL with the button already held sees btn_db_d=1: no pulse.
                MANUAL:    ce_next = btn_db & ~btn_db_d;
                default:   ce_next = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_s1   <= 2'b11;
            mode_s    <= 2'b11;
            mode_q    <= HALT;
            btn_s1    <= 1'b0;
            btn_s     <= 1'b0;
            btn_db    <= 1'b0;
            btn_db_d  <= 1'b0;
            db_cnt    <= '0;
            prescaler <= '0;
            cpu_ce    <= 1'b0;
            ce_count  <= 8'd0;
        end else begin
            mode_s1  <= mode;
            mode_s   <= mode_s1;
            mode_q   <= state_t'(mode_s);
            btn_s1   <= step_btn;
            btn_s    <= btn_s1;
            btn_db_d <= btn_db;

            // Any sample that agrees with the accepted level restarts the count,
            // so only an unbroken run of DEBOUNCE_CYCLES differing samples is taken.
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_M1) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            // Clearing on entry makes the first pulse land exactly DIV cycles later.
            if (mode_chg || mode_q == MANUAL || mode_q == HALT) begin
                prescaler <= '0;
            end else if (prescaler == div_m1) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            cpu_ce <= ce_next;
            if (ce_next) begin
                ce_count <= ce_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_td4_clock_gen.sv
// tb_td4_clock_gen
//   Bench for td4_clock_gen with CLK_FREQ=20, DEBOUNCE_CYCLES=4. A reference
//   model keeps per-edge histories of the raw inputs since the last reset and
//   derives the expected enable and count from them every cycle; directed
//   sequences add latency and pulse-count checks on top.

module tb_td4_clock_gen;

    localparam int CLK_FREQ = 20;
    localparam int DEB      = 4;
    localparam int MAXK     = 8192;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       step_btn = 1'b0;
    logic       cpu_ce;
    logic [7:0] ce_count;

    td4_clock_gen #(
        .CLK_FREQ        (CLK_FREQ),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mode     (mode),
        .step_btn (step_btn),
        .cpu_ce   (cpu_ce),
        .ce_count (ce_count)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Histories indexed by rising edge number since reset release (edge 1 is the first).
    int rm [MAXK];   // raw mode sampled at the edge
    int rb [MAXK];   // raw button sampled at the edge
    int mq [MAXK];   // effective mode after the edge
    int sb [MAXK];   // synchronised button after the edge
    int db [MAXK];   // accepted button level after the edge
    int k       = 0;
    int ent     = 0;
    int exp_cnt = 0;
    int seen    = 0;

    function automatic int div_of(input int m);
        return (m == 0) ? CLK_FREQ : CLK_FREQ / 10;
    endfunction

    function automatic int sbv(input int j);
        return (j < 0) ? 0 : sb[j];
    endfunction

    function automatic int dbv(input int j);
        return (j < 0) ? 0 : db[j];
    endfunction

    always @(posedge clock) begin : mon
        int m_in;
        int b_in;
        int want;
        int same;
        m_in = int'(mode);
        b_in = int'(step_btn);
        #1;
        if (reset) begin
            k = 0; ent = 0; exp_cnt = 0;
            mq[0] = 3; sb[0] = 0; db[0] = 0; rm[0] = 3; rb[0] = 0;
            chk("rst_ce", int'(cpu_ce), 0);
            chk("rst_cnt", int'(ce_count), 0);
        end else if (k < MAXK - 1) begin
            k++;
            rm[k] = m_in;
            rb[k] = b_in;
            // two synchroniser flops then the state register
            mq[k] = (k >= 3) ? rm[k-2] : 3;
            sb[k] = (k >= 2) ? rb[k-1] : 0;
            // a level is accepted once it has been seen DEB samples in a row
            same = 1;
            for (int j = k - DEB; j < k; j++)
                if (sbv(j) != sbv(k-1)) same = 0;
            db[k] = (same == 1 && sbv(k-1) != db[k-1]) ? sbv(k-1) : db[k-1];
            want = 0;
            if (mq[k] == mq[k-1]) begin
                if (mq[k-1] <= 1 && ((k - ent) % div_of(mq[k-1])) == 0) want = 1;
                if (mq[k-1] == 2 && db[k-1] == 1 && dbv(k-2) == 0) want = 1;
            end
            if (mq[k] != mq[k-1]) ent = k;
            exp_cnt = (exp_cnt + want) % 256;
            chk("ce", int'(cpu_ce), want);
            chk("cnt", int'(ce_count), exp_cnt);
            if (cpu_ce) seen++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Edges until the next enable; a missing pulse returns 200 and fails the caller's check.
    task automatic wait_ce(output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!cpu_ce && n < 200);
    endtask

    initial begin : stim
        int n;
        int s0;

        // 1: 1 Hz from reset
        reset = 1'b1; mode = 2'b00; step_btn = 1'b0;
        cyc(3);
        reset = 1'b0;
        wait_ce(n); chk("p1_first", n, 23); chk("p1_cnt1", int'(ce_count), 1);
        wait_ce(n); chk("p1_per2", n, 20);  chk("p1_cnt2", int'(ce_count), 2);
        wait_ce(n); chk("p1_per3", n, 20);  chk("p1_cnt3", int'(ce_count), 3);
        @(posedge clock); #1; chk("p1_width", int'(cpu_ce), 0);

        // 2: 10 Hz, switch to 1 Hz and back
        @(negedge clock); mode = 2'b01;
        wait_ce(n); chk("p2_first10", n, 5);
        wait_ce(n); chk("p2_per10", n, 2);
        @(negedge clock); mode = 2'b00;
        wait_ce(n); chk("p2_inflight", n, 2);
        wait_ce(n); chk("p2_first1", n, 21);
        wait_ce(n); chk("p2_per1", n, 20);
        @(negedge clock); mode = 2'b01;
        wait_ce(n); chk("p2_back10", n, 5);
        wait_ce(n); chk("p2_back_per", n, 2);

        // 3: manual step, glitches rejected
        @(negedge clock); mode = 2'b10;
        cyc(10);
        s0 = seen;
        for (int g = 1; g <= 3; g++) begin
            step_btn = 1'b1; cyc(g);
            step_btn = 1'b0; cyc(5);
        end
        cyc(5);
        chk("p3_glitch", seen - s0, 0);
        s0 = seen;
        step_btn = 1'b1;
        wait_ce(n); chk("p3_lat", n, 7);
        @(negedge clock); cyc(5);
        step_btn = 1'b0;
        cyc(15);
        chk("p3_one", seen - s0, 1);

        // 4: halt ignores the button; entering manual with it held gives nothing
        mode = 2'b11;
        cyc(5);
        s0 = seen;
        for (int i = 0; i < 20; i++) begin
            step_btn = ~step_btn; cyc(10);
        end
        step_btn = 1'b1; cyc(10);
        chk("p4_halt", seen - s0, 0);
        mode = 2'b10; cyc(20);
        chk("p4_enter", seen - s0, 0);
        step_btn = 1'b0; cyc(10);
        step_btn = 1'b1;
        wait_ce(n); chk("p4_press", n, 7);
        @(negedge clock); step_btn = 1'b0; cyc(10);

        // random mode and button activity, checked by the model every cycle
        for (int s = 0; s < 25; s++) begin
            mode = 2'($urandom_range(0, 3));
            for (int i = $urandom_range(20, 60); i > 0; i--) begin
                if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
                cyc(1);
            end
        end

        // 5: count wrap at 10 Hz
        reset = 1'b1; mode = 2'b01; step_btn = 1'b0;
        cyc(2);
        reset = 1'b0;
        wait_ce(n); chk("p5_first", n, 5); chk("p5_cnt1", int'(ce_count), 1);
        for (int i = 2; i <= 255; i++) wait_ce(n);
        chk("p5_255", int'(ce_count), 255);
        wait_ce(n); chk("p5_wrap", int'(ce_count), 0); chk("p5_per", n, 2);

        // 6: asynchronous reset right after a pulse
        wait_ce(n);
        #2 reset = 1'b1;
        #1;
        chk("p6_ce", int'(cpu_ce), 0);
        chk("p6_cnt", int'(ce_count), 0);
        @(negedge clock); cyc(2);
        reset = 1'b0;
        wait_ce(n); chk("p6_first", n, 5); chk("p6_cnt1", int'(ce_count), 1);
        cyc(5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
